// File: rtl/jmp_redirect_seq_if.sv
// Redirect, fetch and RAS status signals between the jump unit, the fetch side
// and the redirect sequencer.
interface jmp_redirect_seq_if #(
    parameter int unsigned DATA_W = 32
);
    logic              iValid;
    logic [1:0]        iKind;
    logic [DATA_W-1:0] iTarget;
    logic [DATA_W-1:0] iRetAdr;
    logic              oReady;
    logic [DATA_W-1:0] oFetchAdr;
    logic              oFetchValid;
    logic              iFetchReady;
    logic              oRasEmpty;
    logic              oRasFull;
    logic              oRasHit;
    logic              oRasMiss;
    logic              oRasOvf;

    modport slave (
        input  iValid, iKind, iTarget, iRetAdr, iFetchReady,
        output oReady, oFetchAdr, oFetchValid,
               oRasEmpty, oRasFull, oRasHit, oRasMiss, oRasOvf
    );

    modport master (
        output iValid, iKind, iTarget, iRetAdr, iFetchReady,
        input  oReady, oFetchAdr, oFetchValid,
               oRasEmpty, oRasFull, oRasHit, oRasMiss, oRasOvf
    );
endinterface

// File: rtl/jmp_redirect_seq.sv
// Fetch PC sequencer: steps the PC by 4 under a fetch handshake, redirects on
// jump-unit requests and keeps a return-address stack for hit/miss prediction.
module jmp_redirect_seq #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       RAS_DEPTH = 8,
    parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    jmp_redirect_seq_if.slave bus
);

    localparam int unsigned       IDX_W    = $clog2(RAS_DEPTH);
    localparam int unsigned       CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(RAS_DEPTH);
    localparam logic [DATA_W-1:0] PC_RST   = {RESET_PC[DATA_W-1:2], 2'b00};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;
    typedef enum logic [1:0] {
        K_JMP = 2'd0,
        K_JSR = 2'd1,
        K_COR = 2'd2,
        K_RET = 2'd3
    } kind_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  sp_q, sp_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] ras_q [RAS_DEPTH];

    logic              ras_we;
    logic [IDX_W-1:0]  ras_waddr;
    kind_e             kind;
    logic [DATA_W-1:0] tgt_al;
    logic [DATA_W-1:0] ret_al;
    logic [IDX_W-1:0]  top_idx;
    logic [DATA_W-1:0] top_val;
    logic              ras_empty;
    logic              ras_full;
    logic              accept;
    logic              unused_lsbs;

    assign kind        = kind_e'(bus.iKind);
    assign tgt_al      = {bus.iTarget[DATA_W-1:2], 2'b00};
    assign ret_al      = {bus.iRetAdr[DATA_W-1:2], 2'b00};
    assign unused_lsbs = ^{bus.iTarget[1:0], bus.iRetAdr[1:0]};
    // sp_q is the next free slot; when full it also points at the oldest entry
    assign top_idx     = sp_q - IDX_W'(1);
    assign top_val     = ras_q[top_idx];
    assign ras_empty   = (count_q == '0);
    assign ras_full    = (count_q == FULL_CNT);
    assign accept      = (state_q == S_RUN) && bus.iValid;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        sp_d      = sp_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        ovf_d     = 1'b0;
        ras_we    = 1'b0;
        ras_waddr = sp_q;
        case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                if (accept) begin
                    state_d = S_FLUSH;
                    pc_d    = tgt_al;
                    case (kind)
                        K_JSR: begin
                            ras_we = 1'b1;
                            sp_d   = sp_q + IDX_W'(1);
                            if (ras_full) ovf_d   = 1'b1;
                            else          count_d = count_q + CNT_W'(1);
                        end
                        K_RET: begin
                            if (ras_empty) begin
                                miss_d = 1'b1;
                            end else begin
                                hit_d   = (top_val == tgt_al);
                                miss_d  = (top_val != tgt_al);
                                sp_d    = top_idx;
                                count_d = count_q - CNT_W'(1);
                            end
                        end
                        K_COR: begin
                            // Pop then push collapses to an in-place overwrite of the top
                            ras_we = 1'b1;
                            if (ras_empty) begin
                                miss_d  = 1'b1;
                                sp_d    = sp_q + IDX_W'(1);
                                count_d = CNT_W'(1);
                            end else begin
                                hit_d     = (top_val == tgt_al);
                                miss_d    = (top_val != tgt_al);
                                ras_waddr = top_idx;
                            end
                        end
                        default: ;
                    endcase
                end else if (bus.iFetchReady) begin
                    pc_d = pc_q + DATA_W'(4);
                end
            end
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RST;
            count_q <= '0;
            sp_q    <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            sp_q    <= sp_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) ras_q[ras_waddr] <= ret_al;
    end

    assign bus.oReady      = (state_q == S_RUN);
    assign bus.oFetchValid = (state_q == S_RUN);
    assign bus.oFetchAdr   = pc_q;
    assign bus.oRasEmpty   = ras_empty;
    assign bus.oRasFull    = ras_full;
    assign bus.oRasHit     = hit_q;
    assign bus.oRasMiss    = miss_q;
    assign bus.oRasOvf     = ovf_q;

endmodule

// File: tb/tb_jmp_redirect_seq.sv
// Directed bench for jmp_redirect_seq: PC sequencing, redirects, RAS hit/miss/ovf.
module tb_jmp_redirect_seq;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned RAS_DEPTH = 8;
    localparam logic [1:0]  K_JMP = 2'd0;
    localparam logic [1:0]  K_JSR = 2'd1;
    localparam logic [1:0]  K_COR = 2'd2;
    localparam logic [1:0]  K_RET = 2'd3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    jmp_redirect_seq_if #(.DATA_W(DATA_W)) bus ();

    jmp_redirect_seq #(
        .DATA_W   (DATA_W),
        .RAS_DEPTH(RAS_DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a redirect in RUN; returns in the FLUSH cycle with iValid dropped.
    task automatic issue(input logic [1:0] kind, input logic [31:0] tgt, input logic [31:0] ret);
        bus.iValid  = 1'b1;
        bus.iKind   = kind;
        bus.iTarget = tgt;
        bus.iRetAdr = ret;
        tick();
        bus.iValid  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        rst             = 1'b1;
        bus.iValid      = 1'b0;
        bus.iFetchReady = 1'b1;
        tick();
        tick();
        checks++; if (bus.oFetchValid !== 1'b0) begin failures++; $display("FAIL rst_fvalid got=%b exp=0", bus.oFetchValid); end
        checks++; if (bus.oReady !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.oReady); end
        checks++; if (bus.oRasEmpty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", bus.oRasEmpty); end
        checks++; if (bus.oRasFull !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", bus.oRasFull); end
        checks++; if ({bus.oRasHit, bus.oRasMiss, bus.oRasOvf} !== 3'b000) begin
            failures++; $display("FAIL rst_pulses got=%b exp=000", {bus.oRasHit, bus.oRasMiss, bus.oRasOvf});
        end
        rst = 1'b0;
        tick();
        checks++; if (bus.oFetchValid !== 1'b0 && 1'b0) begin failures++; end
        checks--;
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'(4 * k);
            checks++; if (bus.oFetchValid !== 1'b1) begin failures++; $display("FAIL seq_fvalid%0d got=%b exp=1", k, bus.oFetchValid); end
            checks++; if (bus.oFetchAdr !== exp_pc) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", k, bus.oFetchAdr, exp_pc); end
            tick();
        end
    endtask

    task automatic test_jmp();
        // RUN with pc=16, fetch side ready during the accept
        checks++; if (bus.oReady !== 1'b1) begin failures++; $display("FAIL jmp_ready got=%b exp=1", bus.oReady); end
        issue(K_JMP, 32'h0000_1003, 32'h0);
        checks++; if (bus.oFetchValid !== 1'b0) begin failures++; $display("FAIL jmp_flush_fvalid got=%b exp=0", bus.oFetchValid); end
        checks++; if (bus.oReady !== 1'b0) begin failures++; $display("FAIL jmp_flush_ready got=%b exp=0", bus.oReady); end
        checks++; if ({bus.oRasHit, bus.oRasMiss, bus.oRasOvf} !== 3'b000) begin
            failures++; $display("FAIL jmp_pulses got=%b exp=000", {bus.oRasHit, bus.oRasMiss, bus.oRasOvf});
        end
        // request raised during FLUSH must wait for RUN
        bus.iValid  = 1'b1;
        bus.iKind   = K_JMP;
        bus.iTarget = 32'h0000_5000;
        tick();
        checks++; if (bus.oFetchAdr !== 32'h0000_1000) begin failures++; $display("FAIL jmp_target got=%h exp=00001000", bus.oFetchAdr); end
        checks++; if (bus.oFetchValid !== 1'b1) begin failures++; $display("FAIL jmp_run_fvalid got=%b exp=1", bus.oFetchValid); end
        tick();
        bus.iValid = 1'b0;
        checks++; if (bus.oFetchValid !== 1'b0) begin failures++; $display("FAIL held_flush got=%b exp=0", bus.oFetchValid); end
        tick();
        checks++; if (bus.oFetchAdr !== 32'h0000_5000) begin failures++; $display("FAIL held_target got=%h exp=00005000", bus.oFetchAdr); end
        bus.iFetchReady = 1'b0;
    endtask

    task automatic test_ras_basic();
        issue(K_JSR, 32'h0000_2000, 32'h0000_0205);
        checks++; if ({bus.oRasHit, bus.oRasMiss, bus.oRasOvf} !== 3'b000) begin
            failures++; $display("FAIL jsr_pulses got=%b exp=000", {bus.oRasHit, bus.oRasMiss, bus.oRasOvf});
        end
        tick();
        checks++; if (bus.oRasEmpty !== 1'b0) begin failures++; $display("FAIL jsr_empty got=%b exp=0", bus.oRasEmpty); end
        issue(K_RET, 32'h0000_0204, 32'h0);
        checks++; if ({bus.oRasHit, bus.oRasMiss} !== 2'b10) begin failures++; $display("FAIL ret_hit got=%b exp=10", {bus.oRasHit, bus.oRasMiss}); end
        tick();
        checks++; if ({bus.oRasHit, bus.oRasMiss} !== 2'b00) begin failures++; $display("FAIL pulse_clear got=%b exp=00", {bus.oRasHit, bus.oRasMiss}); end
        checks++; if (bus.oFetchAdr !== 32'h0000_0204) begin failures++; $display("FAIL ret_pc got=%h exp=00000204", bus.oFetchAdr); end
        checks++; if (bus.oRasEmpty !== 1'b1) begin failures++; $display("FAIL ret_empty got=%b exp=1", bus.oRasEmpty); end
        issue(K_JSR, 32'h0000_2000, 32'h0000_0204);
        tick();
        issue(K_RET, 32'h0000_0208, 32'h0);
        checks++; if ({bus.oRasHit, bus.oRasMiss} !== 2'b01) begin failures++; $display("FAIL ret_miss got=%b exp=01", {bus.oRasHit, bus.oRasMiss}); end
        tick();
        checks++; if (bus.oFetchAdr !== 32'h0000_0208) begin failures++; $display("FAIL miss_pc got=%h exp=00000208", bus.oFetchAdr); end
        checks++; if (bus.oRasEmpty !== 1'b1) begin failures++; $display("FAIL miss_empty got=%b exp=1", bus.oRasEmpty); end
    endtask

    task automatic test_ras_overflow();
        logic        exp_ovf;
        logic        exp_full;
        logic [31:0] exp_top;
        for (int k = 1; k <= RAS_DEPTH + 1; k++) begin
            exp_ovf  = (k == RAS_DEPTH + 1);
            exp_full = (k >= RAS_DEPTH);
            issue(K_JSR, 32'h0000_3000, 32'(16 * k));
            checks++; if (bus.oRasOvf !== exp_ovf) begin failures++; $display("FAIL ovf_push%0d got=%b exp=%b", k, bus.oRasOvf, exp_ovf); end
            tick();
            checks++; if (bus.oRasFull !== exp_full) begin failures++; $display("FAIL full_push%0d got=%b exp=%b", k, bus.oRasFull, exp_full); end
        end
        for (int j = 0; j < RAS_DEPTH; j++) begin
            exp_top = 32'(16 * (RAS_DEPTH + 1 - j));
            issue(K_RET, exp_top, 32'h0);
            checks++; if ({bus.oRasHit, bus.oRasMiss} !== 2'b10) begin
                failures++; $display("FAIL lifo_pop%0d got=%b exp=10 tgt=%h", j, {bus.oRasHit, bus.oRasMiss}, exp_top);
            end
            tick();
        end
        checks++; if (bus.oRasEmpty !== 1'b1) begin failures++; $display("FAIL ovf_drained got=%b exp=1", bus.oRasEmpty); end
    endtask

    task automatic test_coroutine();
        issue(K_RET, 32'h0000_0100, 32'h0);
        checks++; if ({bus.oRasHit, bus.oRasMiss} !== 2'b01) begin failures++; $display("FAIL empty_ret got=%b exp=01", {bus.oRasHit, bus.oRasMiss}); end
        tick();
        checks++; if (bus.oRasEmpty !== 1'b1) begin failures++; $display("FAIL empty_ret_cnt got=%b exp=1", bus.oRasEmpty); end
        issue(K_JSR, 32'h0000_3000, 32'h0000_0300);
        tick();
        issue(K_COR, 32'h0000_0300, 32'h0000_0400);
        checks++; if ({bus.oRasHit, bus.oRasMiss} !== 2'b10) begin failures++; $display("FAIL cor_hit got=%b exp=10", {bus.oRasHit, bus.oRasMiss}); end
        tick();
        checks++; if (bus.oFetchAdr !== 32'h0000_0300) begin failures++; $display("FAIL cor_pc got=%h exp=00000300", bus.oFetchAdr); end
        checks++; if (bus.oRasEmpty !== 1'b0) begin failures++; $display("FAIL cor_cnt got=%b exp=0", bus.oRasEmpty); end
        issue(K_RET, 32'h0000_0400, 32'h0);
        checks++; if ({bus.oRasHit, bus.oRasMiss} !== 2'b10) begin failures++; $display("FAIL cor_newtop got=%b exp=10", {bus.oRasHit, bus.oRasMiss}); end
        tick();
        checks++; if (bus.oRasEmpty !== 1'b1) begin failures++; $display("FAIL cor_cnt1 got=%b exp=1", bus.oRasEmpty); end
        issue(K_COR, 32'h0000_0700, 32'h0000_0800);
        checks++; if ({bus.oRasHit, bus.oRasMiss} !== 2'b01) begin failures++; $display("FAIL cor_empty got=%b exp=01", {bus.oRasHit, bus.oRasMiss}); end
        tick();
        issue(K_RET, 32'h0000_0800, 32'h0);
        checks++; if ({bus.oRasHit, bus.oRasMiss} !== 2'b10) begin failures++; $display("FAIL cor_empty_push got=%b exp=10", {bus.oRasHit, bus.oRasMiss}); end
        tick();
        for (int k = 1; k <= RAS_DEPTH; k++) begin
            issue(K_JSR, 32'h0000_3000, 32'(16 * k));
            tick();
        end
        issue(K_COR, 32'h0000_0080, 32'h0000_0880);
        checks++; if ({bus.oRasHit, bus.oRasMiss, bus.oRasOvf} !== 3'b100) begin
            failures++; $display("FAIL cor_full got=%b exp=100", {bus.oRasHit, bus.oRasMiss, bus.oRasOvf});
        end
        tick();
        checks++; if (bus.oRasFull !== 1'b1) begin failures++; $display("FAIL cor_full_cnt got=%b exp=1", bus.oRasFull); end
        issue(K_RET, 32'h0000_0880, 32'h0);
        checks++; if ({bus.oRasHit, bus.oRasMiss} !== 2'b10) begin failures++; $display("FAIL cor_full_top got=%b exp=10", {bus.oRasHit, bus.oRasMiss}); end
        tick();
    endtask

    task automatic test_wrap_and_reset();
        bus.iFetchReady = 1'b0;
        issue(K_JMP, 32'hFFFF_FFFF, 32'h0);
        tick();
        checks++; if (bus.oFetchAdr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_start got=%h exp=fffffffc", bus.oFetchAdr); end
        bus.iFetchReady = 1'b1;
        tick();
        checks++; if (bus.oFetchAdr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_zero got=%h exp=00000000", bus.oFetchAdr); end
        tick();
        checks++; if (bus.oFetchAdr !== 32'h0000_0004) begin failures++; $display("FAIL wrap_four got=%h exp=00000004", bus.oFetchAdr); end
        // stack holds 0x10..0x70 here; coroutine hit leaves it non-empty
        issue(K_COR, 32'h0000_0070, 32'h0000_0900);
        checks++; if (bus.oRasHit !== 1'b1) begin failures++; $display("FAIL pre_rst_hit got=%b exp=1", bus.oRasHit); end
        test_reset();
    endtask

    initial begin
        rst             = 1'b1;
        bus.iValid      = 1'b0;
        bus.iKind       = K_JMP;
        bus.iTarget     = '0;
        bus.iRetAdr     = '0;
        bus.iFetchReady = 1'b0;
        test_reset();
        test_jmp();
        test_ras_basic();
        test_ras_overflow();
        test_coroutine();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
